// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared widths, field positions, FSM encoding and line helpers
//
// Purpose : single source of truth for the cache controller's geometry.
//           Address layout (byte address): tag[9:6] index[5:4] word[3:2] byte[1:0].
// Ports   : none (package).

package cache_ctrl_pkg;

    localparam int ADDR_W    = 10;
    localparam int NUM_LINES = 4;
    localparam int CNT_W     = 16;

    localparam int TAG_W     = 4;
    localparam int IDX_W     = 2;
    localparam int WOFF_W    = 2;
    localparam int BLOCK_W   = 128;
    localparam int WORD_W    = 32;

    localparam int TAG_LSB   = 6;
    localparam int IDX_LSB   = 4;
    localparam int WOFF_LSB  = 2;

    typedef logic [BLOCK_W-1:0] line_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REFILL = 3'd2,
        ST_MERGE  = 3'd3,
        ST_WTHRU  = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Word w of a line occupies bits [32*w+31 : 32*w].
    function automatic word_t word_sel(input line_t line, input logic [WOFF_W-1:0] w);
        return line[{w, 5'd0} +: WORD_W];
    endfunction

    function automatic line_t word_merge(input line_t line, input logic [WOFF_W-1:0] w,
                                         input word_t wd);
        line_t r;
        r = line;
        r[{w, 5'd0} +: WORD_W] = wd;
        return r;
    endfunction

    // Statistics stick at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - CPU load/store port and block-wide memory port bundle
//
// Purpose : groups the CPU req/ready handshake and the memory req/ack handshake.
// Modports: slave  - the cache controller (answers the CPU, drives memory requests)
//           master - the environment (CPU requester + memory responder)
// Signals : cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU -> cache
//           cpu_rdata/cpu_ready/cpu_hit        cache -> CPU
//           mem_req/mem_we/mem_addr/mem_wdata  cache -> memory
//           mem_rdata/mem_ack                  memory -> cache

interface cache_ctrl_if;
    import cache_ctrl_pkg::*;

    logic               cpu_req;
    logic               cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [WORD_W-1:0]  cpu_wdata;
    logic [WORD_W-1:0]  cpu_rdata;
    logic               cpu_ready;
    logic               cpu_hit;

    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_wdata;
    logic [BLOCK_W-1:0] mem_rdata;
    logic               mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_ctrl_line_array.sv
// rtl/cache_ctrl_line_array.sv - valid/tag/data storage for the direct-mapped lines
//
// Purpose : holds NUM_LINES lines. Combinational read by index, one synchronous
//           write port that loads tag+data and sets the valid bit.
// Ports   : clk, rst_n             clock, synchronous active-low reset (clears valid only)
//           i_rd_idx               line selected for lookup
//           o_rd_valid/tag/data    contents of the selected line
//           i_wr_en/idx/tag/data   write port; a write always marks the line valid

module cache_ctrl_line_array
    import cache_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output line_t            o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  line_t            i_wr_data
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    line_t                r_data [NUM_LINES];

    // Reset wins over a coincident write, so an aborted refill never leaves a valid line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset; they are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - 4-line direct-mapped write-through write-allocate cache controller
//
// Purpose : sequences lookup, refill and write-through between one CPU load/store
//           port and a 128-bit block memory port; counts hits and misses.
// Ports   : clk       clock
//           rst_n     synchronous active-low reset (aborts any memory transaction)
//           bus       cache_ctrl_if.slave (CPU req/ready side, memory req/ack side)
//           hit_cnt   saturating hit count
//           miss_cnt  saturating miss count

module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    cache_ctrl_if.slave  bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    state_t                     r_state;
    logic                       r_we;
    logic [ADDR_W-1:WOFF_LSB]   r_addr;     // byte offset is never needed
    word_t                      r_wdata;
    logic                       r_hit;
    cnt_t                       r_hit_cnt;
    cnt_t                       r_miss_cnt;

    logic                       r_cpu_ready;
    word_t                      r_cpu_rdata;
    logic                       r_cpu_hit;
    logic                       r_mem_req;
    logic                       r_mem_we;
    logic [ADDR_W-1:0]          r_mem_addr;
    line_t                      r_mem_wdata;

    logic [TAG_W-1:0]           w_tag;
    logic [IDX_W-1:0]           w_idx;
    logic [WOFF_W-1:0]          w_woff;
    logic [ADDR_W-1:0]          w_blk_addr;
    logic                       w_line_valid;
    logic [TAG_W-1:0]           w_line_tag;
    line_t                      w_line_data;
    logic                       w_lookup_hit;
    line_t                      w_merged;
    logic                       w_arr_we;
    line_t                      w_arr_wdata;
    logic                       w_unused_byte_off;

    assign w_unused_byte_off = ^bus.cpu_addr[WOFF_LSB-1:0];

    assign w_tag      = r_addr[ADDR_W-1:TAG_LSB];
    assign w_idx      = r_addr[TAG_LSB-1:IDX_LSB];
    assign w_woff     = r_addr[IDX_LSB-1:WOFF_LSB];
    assign w_blk_addr = {w_tag, w_idx, 4'b0000};

    cache_ctrl_line_array u_lines (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_arr_we),
        .i_wr_idx   (w_idx),
        .i_wr_tag   (w_tag),
        .i_wr_data  (w_arr_wdata)
    );

    assign w_lookup_hit = w_line_valid && (w_line_tag == w_tag);

    // In MERGE the line array already holds the target line (hit or fresh refill).
    assign w_merged = word_merge(w_line_data, w_woff, r_wdata);

    // Two writers share the array port: refill data on ack, and the merged store line.
    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_wdata = bus.mem_rdata;
        if (r_state == ST_REFILL && bus.mem_ack) begin
            w_arr_we = 1'b1;
        end else if (r_state == ST_MERGE) begin
            w_arr_we    = 1'b1;
            w_arr_wdata = w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_hit       <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_cpu_hit   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_cpu_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cpu_req) begin
                        r_we    <= bus.cpu_we;
                        r_addr  <= bus.cpu_addr[ADDR_W-1:WOFF_LSB];
                        r_wdata <= bus.cpu_wdata;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_hit <= w_lookup_hit;
                    if (w_lookup_hit) begin
                        r_hit_cnt <= sat_inc(r_hit_cnt);
                        if (r_we) begin
                            r_state <= ST_MERGE;
                        end else begin
                            r_cpu_ready <= 1'b1;
                            r_cpu_rdata <= word_sel(w_line_data, w_woff);
                            r_cpu_hit   <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end else begin
                        r_miss_cnt <= sat_inc(r_miss_cnt);
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_blk_addr;
                        r_state    <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_we) begin
                            r_state <= ST_MERGE;
                        end else begin
                            // Forward the load word straight from the refill beat.
                            r_cpu_ready <= 1'b1;
                            r_cpu_rdata <= word_sel(bus.mem_rdata, w_woff);
                            r_cpu_hit   <= r_hit;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_MERGE: begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_blk_addr;
                    r_mem_wdata <= w_merged;
                    r_state     <= ST_WTHRU;
                end
                ST_WTHRU: begin
                    if (bus.mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        r_cpu_rdata <= '0;
                        r_cpu_hit   <= r_hit;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_cpu_rdata <= '0;
                    r_cpu_hit   <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ready = r_cpu_ready;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_hit   = r_cpu_hit;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - self-checking bench for cache_ctrl with a behavioural cache/memory model

module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    cache_ctrl_if bus_if ();

    cache_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if.slave),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: cache contents by line index, memory by block address.
    bit           m_valid [4];
    int           m_tag   [4];
    logic [127:0] m_data  [4];
    logic [127:0] mem [int];
    int           m_hits = 0;
    int           m_misses = 0;
    int           ack_delay = -1;

    logic [31:0]  last_rdata;
    bit           last_hit;
    logic [127:0] last_wthru;

    function automatic logic [127:0] mem_block(input int a);
        if (!mem.exists(a)) mem[a] = {$urandom, $urandom, $urandom, $urandom};
        return mem[a];
    endfunction

    task automatic run_req(input bit we, input int addr, input logic [31:0] wd, input string tag);
        int           idx = (addr / 16) % 4;
        int           atag = addr / 64;
        int           w = (addr / 4) % 4;
        int           blk = (addr / 16) * 16;
        bit           exp_hit;
        bit           ph_we;
        bit           done;
        logic [127:0] line;
        logic [31:0]  exp_rdata;
        logic [9:0]   held_addr;
        int           exp_txns, txn, n, ack_n, d;

        exp_hit   = m_valid[idx] && (m_tag[idx] == atag);
        line      = exp_hit ? m_data[idx] : mem_block(blk);
        exp_rdata = we ? 32'h0 : line[w*32 +: 32];
        if (we) line[w*32 +: 32] = wd;
        exp_txns  = (exp_hit ? 0 : 1) + (we ? 1 : 0);

        m_valid[idx] = 1'b1;
        m_tag[idx]   = atag;
        m_data[idx]  = line;
        if (exp_hit) m_hits   = (m_hits == 65535) ? m_hits : m_hits + 1;
        else         m_misses = (m_misses == 65535) ? m_misses : m_misses + 1;

        bus_if.cpu_req   = 1'b1;
        bus_if.cpu_we    = we;
        bus_if.cpu_addr  = addr[9:0];
        bus_if.cpu_wdata = wd;
        @(negedge clk);
        bus_if.cpu_req = 1'b0;
        n = 1; txn = 0; ack_n = 0; done = 1'b0;

        while (!done && n < 80) begin
            if (bus_if.cpu_ready) begin
                check({tag, ":rdata"}, bus_if.cpu_rdata, exp_rdata);
                check({tag, ":hit"}, bus_if.cpu_hit, exp_hit);
                check({tag, ":latency"}, n, (exp_txns == 0) ? 2 : ack_n + 1);
                check({tag, ":mem_txns"}, txn, exp_txns);
                last_rdata = bus_if.cpu_rdata;
                last_hit   = bus_if.cpu_hit;
                done = 1'b1;
            end else if (bus_if.mem_req) begin
                ph_we = we && (txn == exp_txns - 1);
                check({tag, ":mem_we"}, bus_if.mem_we, ph_we);
                check({tag, ":mem_addr"}, bus_if.mem_addr, blk);
                if (ph_we) begin
                    check({tag, ":mem_wdata"}, bus_if.mem_wdata, line);
                    last_wthru = bus_if.mem_wdata;
                end
                held_addr = bus_if.mem_addr;
                d = (ack_delay >= 0) ? ack_delay : $urandom_range(0, 3);
                repeat (d) begin
                    @(negedge clk);
                    n++;
                    check({tag, ":mem_req_held"}, {bus_if.mem_req, bus_if.mem_addr}, {1'b1, held_addr});
                end
                bus_if.mem_ack   = 1'b1;
                bus_if.mem_rdata = ph_we ? {$urandom, $urandom, $urandom, $urandom} : mem_block(blk);
                ack_n = n;
                @(negedge clk);
                n++;
                bus_if.mem_ack   = 1'b0;
                bus_if.mem_rdata = '0;
                check({tag, ":mem_req_drop"}, bus_if.mem_req, 1'b0);
                if (ph_we) mem[blk] = line;
                txn++;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!done) check({tag, ":ready_timeout"}, 1'b0, 1'b1);
        check({tag, ":hit_cnt"}, hit_cnt, m_hits);
        check({tag, ":miss_cnt"}, miss_cnt, m_misses);
        @(negedge clk);
        check({tag, ":ready_pulse"}, bus_if.cpu_ready, 1'b0);
    endtask

    logic [127:0] orig;
    bit           rnd_we;
    int           rnd_addr;
    int           wait_n;
    bit           seen;

    initial begin
        bus_if.cpu_req   = 1'b0;
        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_addr  = '0;
        bus_if.cpu_wdata = '0;
        bus_if.mem_rdata = '0;
        bus_if.mem_ack   = 1'b0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst:cpu_ready", bus_if.cpu_ready, 1'b0);
        check("rst:cpu_rdata", bus_if.cpu_rdata, 32'h0);
        check("rst:cpu_hit", bus_if.cpu_hit, 1'b0);
        check("rst:mem_req", bus_if.mem_req, 1'b0);
        check("rst:mem_we", bus_if.mem_we, 1'b0);
        check("rst:mem_addr", bus_if.mem_addr, 10'h0);
        check("rst:mem_wdata", bus_if.mem_wdata, 128'h0);
        check("rst:cnts", {hit_cnt, miss_cnt}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: cold read miss, ack three cycles after mem_req
        mem[0] = 128'h44444444_33333333_22222222_11111111;
        ack_delay = 3;
        run_req(1'b0, 'h000, 32'h0, "t1");
        check("t1:rdata_k", last_rdata, 32'h11111111);
        check("t1:hit_k", last_hit, 1'b0);
        check("t1:miss_k", miss_cnt, 16'd1);

        // 2: read hit in the same line
        run_req(1'b0, 'h004, 32'h0, "t2");
        check("t2:rdata_k", last_rdata, 32'h22222222);
        check("t2:hit_k", last_hit, 1'b1);
        check("t2:hitcnt_k", hit_cnt, 16'd1);

        // 3: write hit with write-through, then read it back
        run_req(1'b1, 'h008, 32'hDEADBEEF, "t3");
        check("t3:hit_k", last_hit, 1'b1);
        check("t3:wthru_k", last_wthru, 128'h44444444_DEADBEEF_22222222_11111111);
        run_req(1'b0, 'h008, 32'h0, "t3r");
        check("t3r:rdata_k", last_rdata, 32'hDEADBEEF);

        // 4: conflict on index 0
        ack_delay = -1;
        run_req(1'b0, 'h040, 32'h0, "t4a");
        check("t4a:hit_k", last_hit, 1'b0);
        run_req(1'b0, 'h000, 32'h0, "t4b");
        check("t4b:hit_k", last_hit, 1'b0);
        check("t4b:rdata_k", last_rdata, 32'h11111111);

        // 5: write miss allocates then writes through
        orig = mem_block('h3F0);
        run_req(1'b1, 'h3F4, 32'h12345678, "t5");
        check("t5:hit_k", last_hit, 1'b0);
        check("t5:wthru_k", last_wthru, {orig[127:64], 32'h12345678, orig[31:0]});

        // 6: reset while a refill is outstanding
        bus_if.cpu_req  = 1'b1;
        bus_if.cpu_we   = 1'b0;
        bus_if.cpu_addr = 10'h2A4;
        @(negedge clk);
        bus_if.cpu_req = 1'b0;
        wait_n = 0;
        while (!bus_if.mem_req && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        check("t6:refill_started", bus_if.mem_req, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6:mem_req_abort", bus_if.mem_req, 1'b0);
        check("t6:cnts_cleared", {hit_cnt, miss_cnt}, 32'h0);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = {4{32'hA5A5A5A5}};
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            if (bus_if.cpu_ready || bus_if.mem_req) seen = 1'b1;
            @(negedge clk);
        end
        check("t6:stray_ack_ignored", seen, 1'b0);
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        run_req(1'b0, 'h004, 32'h0, "t6");
        check("t6:hit_k", last_hit, 1'b0);

        // Randomised traffic over a few tags to mix hits, conflicts and write misses.
        for (int i = 0; i < 80; i++) begin
            rnd_we   = 1'($urandom_range(0, 1));
            rnd_addr = ($urandom_range(0, 2) << 6) | $urandom_range(0, 63);
            run_req(rnd_we, rnd_addr, $urandom, "rnd");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
